// File: rtl/impulse_pkg.sv
// Shared definitions for the impulse counter front end: edge-mode encodings
// and the default channel count.
package impulse_pkg;

    localparam int unsigned N_CH_DEFAULT = 8;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_e;

endpackage

// File: rtl/impulse_chan_filter.sv
// One input lane: synchroniser, glitch filter, stable register and edge events.
// The glitch filter is built only when IMPULSE_GLITCH_FILTER_EN is defined.
module impulse_chan_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic prime,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out;
    logic                   stable_q, stable_d;
    logic                   accept;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din};
        sync_out = sync_q[SYNC_STAGES-1];
    end

`ifdef IMPULSE_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        if (prime) begin
            stable_d = sync_out;
            cnt_d    = '0;
        end else if (sync_out == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync_out;
            cnt_d    = '0;
            accept   = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    // Filter length has no meaning without the filter.
    localparam int unsigned FILTER_LEN_unused = FILTER_LEN;

    always_comb begin
        stable_d = sync_out;
        accept   = !prime && (sync_out != stable_q);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
        end
    end

    always_comb begin
        level = stable_q;
        rise  = accept && sync_out;
        fall  = accept && !sync_out;
    end

endmodule

// File: rtl/impulse_input_conditioner.sv
// Impulse counter front end: N_CH channels plus RTC reference, synchronised,
// filtered and turned into registered edge pulses. Filter: IMPULSE_GLITCH_FILTER_EN.
module impulse_input_conditioner
    import impulse_pkg::*;
#(
    parameter int unsigned N_CH        = N_CH_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [1:0]      edge_mode,
    input  logic [N_CH-1:0] ch_in,
    input  logic            rtc_in,
    output logic [N_CH-1:0] ch_pulse,
    output logic [N_CH-1:0] ch_level,
    output logic            rtc_tick,
    output logic            any_pulse
);

    localparam int unsigned PRIME_INIT = SYNC_STAGES + 1;
    localparam int unsigned PRIME_W    =
        ($clog2(PRIME_INIT + 1) > 2) ? $clog2(PRIME_INIT + 1) : 2;

    logic [PRIME_W-1:0] prime_q, prime_d;
    logic               priming;
    edge_mode_e         mode_q, mode_d;
    logic [N_CH-1:0]    ch_rise, ch_fall, qual;
    logic               rtc_rise, rtc_fall_unused;
    logic [N_CH-1:0]    ch_pulse_q, ch_pulse_d;
    logic               rtc_tick_q, rtc_tick_d;
    logic               any_pulse_q, any_pulse_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        impulse_chan_filter #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .prime(priming),
            .din  (ch_in[i]),
            .level(ch_level[i]),
            .rise (ch_rise[i]),
            .fall (ch_fall[i])
        );
    end

    impulse_chan_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_rtc (
        .clk  (clk),
        .rst_n(rst_n),
        .prime(priming),
        .din  (rtc_in),
        .level(),
        .rise (rtc_rise),
        .fall (rtc_fall_unused)
    );

    always_comb begin
        priming = (prime_q != '0);
        prime_d = priming ? prime_q - PRIME_W'(1) : prime_q;
        mode_d  = edge_mode_e'(edge_mode);
    end

    // Events are qualified by the edge mode registered on the previous edge.
    always_comb begin
        qual = '0;
        unique case (mode_q)
            EDGE_RISE: qual = ch_rise;
            EDGE_FALL: qual = ch_fall;
            EDGE_BOTH: qual = ch_rise | ch_fall;
            EDGE_NONE: qual = '0;
        endcase
        ch_pulse_d  = ena ? qual : '0;
        rtc_tick_d  = ena && rtc_rise;
        any_pulse_d = ena && ((|ch_pulse_q) || rtc_tick_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prime_q     <= PRIME_W'(PRIME_INIT);
            mode_q      <= EDGE_RISE;
            ch_pulse_q  <= '0;
            rtc_tick_q  <= 1'b0;
            any_pulse_q <= 1'b0;
        end else begin
            prime_q     <= prime_d;
            mode_q      <= mode_d;
            ch_pulse_q  <= ch_pulse_d;
            rtc_tick_q  <= rtc_tick_d;
            any_pulse_q <= any_pulse_d;
        end
    end

    always_comb begin
        ch_pulse  = ch_pulse_q;
        rtc_tick  = rtc_tick_q;
        any_pulse = any_pulse_q;
    end

endmodule

// File: tb/tb_impulse_input_conditioner.sv
// Scoreboard bench for impulse_input_conditioner: a behavioural model predicts
// every output cycle, a monitor compares; directed scenarios add count checks.
module tb_impulse_input_conditioner;

    localparam int SYNC = 2;
`ifdef IMPULSE_GLITCH_FILTER_EN
    localparam int FLEN = 3;
`else
    localparam int FLEN = 1;
`endif
    localparam int LAT = SYNC + FLEN - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [1:0] edge_mode;
    logic [7:0] ch_in;
    logic       rtc_in;
    logic [7:0] ch_pulse;
    logic [7:0] ch_level;
    logic       rtc_tick;
    logic       any_pulse;

    impulse_input_conditioner #(
        .N_CH       (8),
        .SYNC_STAGES(SYNC),
        .FILTER_LEN (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .edge_mode(edge_mode),
        .ch_in    (ch_in),
        .rtc_in   (rtc_in),
        .ch_pulse (ch_pulse),
        .ch_level (ch_level),
        .rtc_tick (rtc_tick),
        .any_pulse(any_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pulse;
        logic [7:0] level;
        logic       rtc;
        logic       any;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cnt1 = 0, cnt3 = 0, cnt5 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each input is seen SYNC edges late; a level change is
    // accepted once FLEN consecutive samples disagree with the current level.
    logic [8:0] hist[$];
    logic [8:0] m_stable;
    int         m_run[9];
    int         m_prime;
    logic [1:0] m_mode;
    logic [7:0] m_pulse_prev;
    logic       m_rtc_prev;

    always @(posedge clk) begin
        exp_t       e;
        logic [8:0] s, rise, fall;
        logic [7:0] q;
        e = '0;
        if (!rst_n) begin
            hist.delete();
            for (int k = 0; k < SYNC; k++) hist.push_back(9'd0);
            m_stable = '0;
            for (int k = 0; k < 9; k++) m_run[k] = 0;
            m_prime = SYNC + 1;
            m_mode  = 2'b00;
        end else begin
            s = hist.pop_front();
            hist.push_back({rtc_in, ch_in});
            rise = '0;
            fall = '0;
            for (int k = 0; k < 9; k++) begin
                if (m_prime > 0) begin
                    m_stable[k] = s[k];
                    m_run[k]    = 0;
                end else if (s[k] == m_stable[k]) begin
                    m_run[k] = 0;
                end else begin
                    m_run[k]++;
                    if (m_run[k] == FLEN) begin
                        m_stable[k] = s[k];
                        m_run[k]    = 0;
                        if (s[k]) rise[k] = 1'b1;
                        else      fall[k] = 1'b1;
                    end
                end
            end
            if (m_prime > 0) m_prime--;
            case (m_mode)
                2'b00:   q = rise[7:0];
                2'b01:   q = fall[7:0];
                2'b10:   q = rise[7:0] | fall[7:0];
                default: q = '0;
            endcase
            e.pulse = ena ? q : 8'h00;
            e.rtc   = ena && rise[8];
            e.any   = ena && ((m_pulse_prev != 0) || m_rtc_prev);
            e.level = m_stable[7:0];
            m_mode  = edge_mode;
        end
        m_pulse_prev = e.pulse;
        m_rtc_prev   = e.rtc;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ch_pulse", 32'(ch_pulse), 32'(e.pulse));
            check("ch_level", 32'(ch_level), 32'(e.level));
            check("rtc_tick", 32'(rtc_tick), 32'(e.rtc));
            check("any_pulse", 32'(any_pulse), 32'(e.any));
        end
        if (ch_pulse[1] === 1'b1) cnt1++;
        if (ch_pulse[3] === 1'b1) cnt3++;
        if (ch_pulse[5] === 1'b1) cnt5++;
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        int   base;
        logic found;
        rst_n     = 1'b0;
        ena       = 1'b1;
        edge_mode = 2'b00;
        ch_in     = 8'hFF;
        rtc_in    = 1'b0;
        idle(4);

        // Inputs held high through reset: level appears, no pulse.
        rst_n = 1'b1;
        base  = cnt1 + cnt3 + cnt5;
        idle(3);
        check("prime_level", 32'(ch_level), 32'hFF);
        idle(4);
        check("prime_no_pulse", 32'(cnt1 + cnt3 + cnt5 - base), 0);
        ch_in = 8'h00;
        idle(10);

        // Single rising edge latency and width.
        ch_in[0] = 1'b1;
        for (int k = 0; k <= LAT + 2; k++) begin
            @(negedge clk);
            check("latency_ch0", 32'(ch_pulse[0]), (k == LAT) ? 32'd1 : 32'd0);
        end
        ch_in[0] = 1'b0;
        idle(10);

        // Two-cycle glitch on channel 3.
        base = cnt3;
        ch_in[3] = 1'b1;
        idle(2);
        ch_in[3] = 1'b0;
        idle(10);
        check("glitch_pulses", 32'(cnt3 - base), (FLEN > 2) ? 32'd0 : 32'd1);
        check("glitch_level", 32'(ch_level[3]), 32'd0);

        // Square wave on channel 5: both edges, then no edges.
        for (int m = 2; m <= 3; m++) begin
            edge_mode = 2'(m);
            base = cnt5;
            for (int p = 0; p < 4; p++) begin
                ch_in[5] = 1'b1;
                idle(6);
                ch_in[5] = 1'b0;
                idle(6);
            end
            idle(10);
            check((m == 2) ? "square_both" : "square_none", 32'(cnt5 - base),
                  (m == 2) ? 32'd8 : 32'd0);
        end
        edge_mode = 2'b00;
        idle(2);

        // Edge while disabled must never surface.
        base = cnt1;
        ena = 1'b0;
        ch_in[1] = 1'b1;
        idle(10);
        ena = 1'b1;
        idle(10);
        check("ena_no_pulse", 32'(cnt1 - base), 0);
        check("ena_level", 32'(ch_level[1]), 32'd1);
        ch_in[1] = 1'b0;
        idle(10);

        // Everything rises together.
        ch_in  = 8'hFF;
        rtc_in = 1'b1;
        found  = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (ch_pulse == 8'hFF) found = 1'b1;
        end
        check("all_rise_seen", 32'(found), 32'd1);
        if (found) begin
            check("all_rise_rtc", 32'(rtc_tick), 32'd1);
            @(negedge clk);
            check("all_rise_any", 32'(any_pulse), 32'd1);
        end
        ch_in  = 8'h00;
        rtc_in = 1'b0;
        idle(10);

        // Randomised traffic with occasional mode/enable changes and resets.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 4) == 0) ch_in[b] = ~ch_in[b];
            if ($urandom_range(0, 4) == 0) rtc_in = ~rtc_in;
            if ($urandom_range(0, 19) == 0) edge_mode = 2'($urandom_range(0, 3));
            ena   = ($urandom_range(0, 7) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        ena   = 1'b1;
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
